// File: rtl/top_ntt_mul_arbiter_if.sv
// Requester-side and response-side handshake bundle for the shared NTT multiplier arbiter.
// The master modport is the requester/consumer side, the slave modport is the arbiter.
interface top_ntt_mul_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [63:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/top_ntt_mul_arbiter.sv
// Round-robin arbiter feeding one shared 32x32->64 unsigned multiplier through a
// two-stage valid/ready pipeline; products come back tagged with the requester index.
module top_ntt_mul_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    top_ntt_mul_arbiter_if.slave  bus
);
    localparam int              DATA_W    = 32;
    localparam logic [ID_W:0]   NREQ      = NUM_REQ[ID_W:0];
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

    function automatic logic [2*DATA_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        return {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    endfunction

    logic                  vld_p1;
    logic [DATA_W-1:0]     a_p1;
    logic [DATA_W-1:0]     b_p1;
    logic [ID_W-1:0]       id_p1;
    logic                  vld_p2;
    logic [2*DATA_W-1:0]   data_p2;
    logic [ID_W-1:0]       id_p2;
    logic [ID_W-1:0]       last_id;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_id;
    logic                  grant_any;
    logic [ID_W:0]         cand;
    logic [DATA_W-1:0]     sel_a;
    logic [DATA_W-1:0]     sel_b;
    logic                  s2_free;
    logic                  s1_free;
    logic                  accept;

    assign s2_free = !vld_p2 || bus.rsp_ready;
    assign s1_free = !vld_p1 || s2_free;
    assign accept  = grant_any && s1_free;

    // Rotating search starting just after the last winner; cand wraps once at NUM_REQ.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_id} + k[ID_W:0];
            if (cand >= NREQ) cand = cand - NREQ;
            if (!grant_any && bus.req_valid[cand[ID_W-1:0]]) begin
                grant[cand[ID_W-1:0]] = 1'b1;
                grant_id              = cand[ID_W-1:0];
                grant_any             = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = bus.req_a[i*DATA_W +: DATA_W];
                sel_b = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.req_ready = (ap_rst || !s1_free) ? '0 : grant;

    // Stage 1 boundary: granted operands registered, they drive the multiplier.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_p1  <= 1'b0;
            last_id <= LAST_INIT;
        end else if (s1_free) begin
            vld_p1 <= grant_any;
            if (grant_any) last_id <= grant_id;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (accept) begin
            a_p1  <= sel_a;
            b_p1  <= sel_b;
            id_p1 <= grant_id;
        end
    end

    // Stage 2 boundary: product and tag registered as the response.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            id_p2   <= '0;
        end else if (s2_free) begin
            vld_p2  <= vld_p1;
            data_p2 <= mul_full(a_p1, b_p1);
            id_p2   <= id_p1;
        end
    end

    assign bus.rsp_valid = vld_p2;
    assign bus.rsp_data  = data_p2;
    assign bus.rsp_id    = id_p2;
    assign bus.busy      = vld_p1 || vld_p2;
endmodule
